// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the pixel arbitration level.
//   LVL_ROWS / LVL_COLS : default pixel-block geometry
//   REFR_W              : width of the per-pixel refractory down-counter
//   px_state_e          : per-pixel FSM state encoding
package lib_arbiter_pkg;

  localparam int LVL_ROWS = 4;
  localparam int LVL_COLS = 4;
  localparam int REFR_W   = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    REFR = 2'b10
  } px_state_e;

endpackage

// File: rtl/pixel_req_source_if.sv
// Event/request/grant bundle between the comparator array, the pixel
// request source and the arbitration level.
//   evt_i : per-pixel single-cycle event strobe
//   gnt_i : grant from the arbitration level (one-hot or zero)
//   req_o : registered per-pixel request
// master = request source (drives req_o), slave = arbiter/stimulus side.
interface pixel_req_source_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic [ROWS-1:0][COLS-1:0] evt_i;
  logic [ROWS-1:0][COLS-1:0] gnt_i;
  logic [ROWS-1:0][COLS-1:0] req_o;

  modport master (input evt_i, input gnt_i, output req_o);
  modport slave  (output evt_i, output gnt_i, input req_o);
endinterface

// File: rtl/pixel_req_source_cell.sv
// Per-pixel request FSM with refractory down-counter.
//   clk_i, reset_i : clock, async active-high reset
//   enable_i       : accept new events when high
//   evt_i, gnt_i   : this pixel's event strobe and grant
//   req_o          : pixel is PEND (request to arbiter)
//   busy_o         : pixel is not IDLE
//   pend_o         : pixel is PEND (used for grant checking)
//   drop_o         : enabled event arrived while pixel was not IDLE
module pixel_cell
  import lib_arbiter_pkg::*;
#(
  parameter int REFRACT_CYC = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic evt_i,
  input  logic gnt_i,
  output logic req_o,
  output logic busy_o,
  output logic pend_o,
  output logic drop_o
);

  px_state_e         state_q, state_d;
  logic [REFR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (evt_i && enable_i) state_d = PEND;
      PEND: begin
        if (gnt_i) begin
          // Zero refractory time skips REFR entirely.
          state_d = (REFRACT_CYC == 0) ? IDLE : REFR;
          cnt_d   = REFR_W'(REFRACT_CYC);
        end
      end
      REFR: begin
        // Counter holds the remaining REFR cycles including this one;
        // leave as it reaches zero.
        cnt_d = cnt_q - REFR_W'(1);
        if (cnt_q <= REFR_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_o  = (state_q == PEND);
  assign pend_o = (state_q == PEND);
  assign busy_o = (state_q != IDLE);
  assign drop_o = evt_i && enable_i && (state_q != IDLE);

endmodule

// File: rtl/pixel_req_source.sv
// Pixel request source: one pixel_cell per pixel, plus block-level drop
// counting and grant protocol checking.
//   clk_i, reset_i : clock, async active-high reset
//   enable_i       : accept new pixel events when high
//   bus            : evt_i / gnt_i in, req_o out (master modport)
//   busy_o         : registered OR of all pixels not IDLE
//   drop_o         : pulse, at least one event dropped last cycle
//   drop_cnt_o     : saturating count of dropped events
//   gnt_err_o      : pulse, grant protocol violation last cycle
module pixel_req_source
  import lib_arbiter_pkg::*;
#(
  parameter int Lvl_ROWS    = LVL_ROWS,
  parameter int Lvl_COLS    = LVL_COLS,
  parameter int REFRACT_CYC = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  pixel_req_source_if.master       bus,
  output logic                     busy_o,
  output logic                     drop_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     gnt_err_o
);

  localparam int NPIX = Lvl_ROWS * Lvl_COLS;
  localparam int PC_W = $clog2(NPIX + 1);

  logic [Lvl_ROWS-1:0][Lvl_COLS-1:0] req, busy_px, pend_px, drop_px;

  for (genvar r = 0; r < Lvl_ROWS; r++) begin : g_row
    for (genvar c = 0; c < Lvl_COLS; c++) begin : g_col
      pixel_cell #(.REFRACT_CYC(REFRACT_CYC)) u_cell (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .evt_i    (bus.evt_i[r][c]),
        .gnt_i    (bus.gnt_i[r][c]),
        .req_o    (req[r][c]),
        .busy_o   (busy_px[r][c]),
        .pend_o   (pend_px[r][c]),
        .drop_o   (drop_px[r][c])
      );
    end
  end

  assign bus.req_o = req;

  logic [NPIX-1:0] drop_flat, gnt_flat, pend_flat;
  assign drop_flat = drop_px;
  assign gnt_flat  = bus.gnt_i;
  assign pend_flat = pend_px;

  logic [PC_W-1:0]  drop_n;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, drop_q, drop_d, gerr_q, gerr_d;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NPIX; i++) drop_n = drop_n + PC_W'(drop_flat[i]);
    cnt_sum = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(drop_n);
    cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    drop_d  = |drop_flat;
    busy_d  = |busy_px;
    // g & (g-1) clears the lowest set bit: nonzero means >1 grant.
    gerr_d  = (|(gnt_flat & (gnt_flat - NPIX'(1)))) || (|(gnt_flat & ~pend_flat));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
      gerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      drop_q <= drop_d;
      gerr_q <= gerr_d;
    end
  end

  assign busy_o     = busy_q;
  assign drop_o     = drop_q;
  assign drop_cnt_o = cnt_q;
  assign gnt_err_o  = gerr_q;

endmodule

// File: tb/tb_pixel_req_source.sv
module tb_pixel_req_source;

  localparam int R = 3;  // refractory cycles

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        busy_o, drop_o, gnt_err_o;
  logic [15:0] drop_cnt_o;

  pixel_req_source_if #(.ROWS(4), .COLS(4)) bus ();

  pixel_req_source #(.Lvl_ROWS(4), .Lvl_COLS(4), .REFRACT_CYC(R)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .drop_o     (drop_o),
    .drop_cnt_o (drop_cnt_o),
    .gnt_err_o  (gnt_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: per pixel, "waiting for grant" flag and cycles of
  // refractory time left; idle when neither applies.
  bit          m_pend [16];
  int          m_refr [16];
  int          m_cnt;
  logic        e_busy, e_drop, e_err;
  int          nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_req();
    logic [15:0] v = '0;
    for (int p = 0; p < 16; p++) v[p] = m_pend[p];
    return v;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 16; p++) begin m_pend[p] = 0; m_refr[p] = 0; end
    m_cnt = 0; e_busy = 0; e_drop = 0; e_err = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},  32'(bus.req_o), 32'(m_req()));
    chk({tag, ".busy"}, 32'(busy_o),    32'(e_busy));
    chk({tag, ".drop"}, 32'(drop_o),    32'(e_drop));
    chk({tag, ".cnt"},  32'(drop_cnt_o), 32'(m_cnt));
    chk({tag, ".gerr"}, 32'(gnt_err_o), 32'(e_err));
  endtask

  // One clock cycle: apply inputs, advance model, check after the edge.
  task automatic tick(input string tag, input logic [15:0] ev, input logic en, input logic [15:0] gn);
    int nd = 0, ng = 0;
    bit idle;
    bus.evt_i = ev; bus.gnt_i = gn; enable_i = en;
    e_busy = 0; e_err = 0;
    for (int p = 0; p < 16; p++) begin
      idle = !m_pend[p] && m_refr[p] == 0;
      if (!idle) e_busy = 1;
      if (ev[p] && en && !idle) nd++;
      if (gn[p]) ng++;
      if (gn[p] && !m_pend[p]) e_err = 1;
    end
    if (ng > 1) e_err = 1;
    e_drop = (nd > 0);
    m_cnt  = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    for (int p = 0; p < 16; p++) begin
      if (m_pend[p]) begin
        if (gn[p]) begin m_pend[p] = 0; m_refr[p] = R; end
      end else if (m_refr[p] > 0) m_refr[p]--;
      else if (ev[p] && en) m_pend[p] = 1;
    end
    @(posedge clk_i); #1;
    check_all(tag);
    bus.evt_i = '0; bus.gnt_i = '0;
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, 16'h0, 1'b1, 16'h0);
  endtask

  function automatic logic [15:0] bit16(input int p);
    logic [15:0] v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [15:0] ev, gn;
    int k;
    bus.evt_i = '0; bus.gnt_i = '0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1; check_all("reset");
    @(negedge clk_i); reset_i = 1'b0;

    // First event right after release; pixel [1][2] latency/refractory.
    tick("p12_evt", bit16(6), 1, 0);
    idle_n("p12_pend", 3);
    tick("p12_gnt", 0, 1, bit16(6));
    idle_n("p12_refr", 5);

    // Pixel [0][0]: re-pulse while PEND, grant, re-pulse in REFR.
    tick("p00_evt", bit16(0), 1, 0);
    tick("p00_w", 0, 1, 0);
    tick("p00_dropP", bit16(0), 1, 0);
    tick("p00_w2", 0, 1, 0);
    tick("p00_gnt", 0, 1, bit16(0));
    tick("p00_r1", 0, 1, 0);
    tick("p00_dropR", bit16(0), 1, 0);
    idle_n("p00_end", 4);

    // All pixels at once, then repeated drops to saturation.
    tick("all_evt", 16'hFFFF, 1, 0);
    for (int i = 0; i < 4100; i++) tick("all_sat", 16'hFFFF, 1, 0);
    for (int p = 0; p < 16; p++) tick("all_gnt", 0, 1, bit16(p));
    idle_n("all_end", 5);

    // Grant protocol errors.
    tick("ge_evt", 16'h8001, 1, 0);
    tick("ge_two", 0, 1, 16'h8001);
    idle_n("ge_w", 5);
    tick("ge_idle", bit16(5), 1, bit16(5));
    tick("ge_idle2", 0, 1, bit16(7));
    tick("ge_ok", 0, 1, bit16(5));
    idle_n("ge_end", 5);

    // enable_i low: events ignored, pending request survives.
    tick("en_off", bit16(9), 0, 0);
    tick("en_on", bit16(9), 1, 0);
    for (int i = 0; i < 3; i++) tick("en_hold", bit16(9), 0, 0);
    tick("en_gnt", 0, 0, bit16(9));
    idle_n("en_end", 5);

    // Async reset mid-REFR with requests pending.
    tick("rst_evt", 16'h0F01, 1, 0);
    tick("rst_gnt", 0, 1, bit16(0));
    tick("rst_evt2", 16'h0010, 1, 0);
    #2 reset_i = 1'b1;
    #1 m_reset();
    check_all("rst_async");
    @(negedge clk_i); reset_i = 1'b0;
    tick("rst_after", bit16(3), 1, 0);
    idle_n("rst_end", 2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ev = 16'($urandom) & 16'($urandom) & 16'($urandom);
      gn = '0;
      k = $urandom_range(0, 19);
      if (k < 14) begin
        for (int j = 0; j < 16; j++) begin
          int p = (j + $urandom_range(0, 15)) % 16;
          if (m_pend[p] && gn == 0) gn = bit16(p);
        end
      end else if (k < 17) gn = bit16($urandom_range(0, 15));
      else if (k < 18) gn = 16'($urandom);
      tick("rand", ev, ($urandom_range(0, 3) != 0), gn);
    end
    idle_n("rand_end", 5);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
